// File: rtl/npc_pkg.sv
// npc_pkg: shared NPC widths and the writeback entry type
package npc_pkg;

    localparam int NPC_ADDR_WIDTH = 5;
    localparam int NPC_DATA_WIDTH = 32;

    typedef struct packed {
        logic [NPC_ADDR_WIDTH-1:0] waddr;
        logic [NPC_DATA_WIDTH-1:0] wdata;
    } wb_entry_t;

endpackage

// File: rtl/wb_queue.sv
// wb_queue: circular buffer of writeback entries with per-entry valid bits
module wb_queue
    import npc_pkg::*;
#(
    parameter int ADDR_WIDTH = NPC_ADDR_WIDTH,
    parameter int DATA_WIDTH = NPC_DATA_WIDTH,
    parameter int DEPTH      = 4,
    localparam int PW        = $clog2(DEPTH),
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_waddr,
    input  logic [DATA_WIDTH-1:0] push_wdata,
    input  logic                  pop,
    output logic [PW-1:0]         head,
    output logic [CW-1:0]         count,
    output logic [DEPTH-1:0]      vld,
    output logic [ADDR_WIDTH-1:0] waddrs [DEPTH],
    output logic [DATA_WIDTH-1:0] wdatas [DEPTH]
);

    logic [PW-1:0] tail;

    // pointers, occupancy and valid bits; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            vld   <= '0;
        end else begin
            if (pop) begin
                head      <= head + 1'b1;
                vld[head] <= 1'b0;
            end
            if (push) begin
                tail      <= tail + 1'b1;
                vld[tail] <= 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // payload storage needs no reset: it is only observed through vld/count
    always_ff @(posedge clk) begin
        if (push) begin
            waddrs[tail] <= push_waddr;
            wdatas[tail] <= push_wdata;
        end
    end

    // the writer must never overfill or underflow the buffer
    always @(posedge clk) begin
        if (rst) begin
            assert (!(push && count == CW'(DEPTH)));
            assert (!(pop && count == '0));
        end
    end

endmodule

// File: rtl/regfile_wb_writer.sv
// regfile_wb_writer: queues writeback results and drains them onto the RegisterFile write port
module regfile_wb_writer
    import npc_pkg::*;
#(
    parameter int ADDR_WIDTH = NPC_ADDR_WIDTH,
    parameter int DATA_WIDTH = NPC_DATA_WIDTH,
    parameter int DEPTH      = 4,
    localparam int PW        = $clog2(DEPTH),
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_waddr,
    input  logic [DATA_WIDTH-1:0] in_wdata,
    input  logic                  rf_grant,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    input  logic [ADDR_WIDTH-1:0] byp_raddr,
    output logic                  byp_hit,
    output logic [DATA_WIDTH-1:0] byp_data,
    output logic [CW-1:0]         pending
);

    logic [PW-1:0]         head;
    logic [CW-1:0]         count;
    logic [DEPTH-1:0]      vld;
    logic [ADDR_WIDTH-1:0] waddrs [DEPTH];
    logic [DATA_WIDTH-1:0] wdatas [DEPTH];
    logic                  push;
    logic                  busy;

    // x0 writes complete the handshake but are never stored
    assign in_ready = rst && count != CW'(DEPTH);
    assign push     = in_valid && in_ready && in_waddr != '0;
    assign busy     = count != '0;
    assign rf_wen   = busy && rf_grant;
    assign rf_waddr = busy ? waddrs[head] : '0;
    assign rf_wdata = busy ? wdatas[head] : '0;
    assign pending  = count;

    wb_queue #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_waddr (in_waddr),
        .push_wdata (in_wdata),
        .pop        (rf_wen),
        .head       (head),
        .count      (count),
        .vld        (vld),
        .waddrs     (waddrs),
        .wdatas     (wdatas)
    );

    // walk oldest to youngest so the last match wins
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[head + PW'(i)] && waddrs[head + PW'(i)] == byp_raddr && byp_raddr != '0) begin
                byp_hit  = 1'b1;
                byp_data = wdatas[head + PW'(i)];
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_writer.sv
// tb_regfile_wb_writer: directed scenarios for the RegisterFile writeback writer
module tb_regfile_wb_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_waddr = '0;
    logic [31:0] in_wdata = '0;
    logic        rf_grant = 1'b0;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  byp_raddr = '0;
    logic        byp_hit;
    logic [31:0] byp_data;
    logic [2:0]  pending;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    regfile_wb_writer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_waddr  (in_waddr),
        .in_wdata  (in_wdata),
        .rf_grant  (rf_grant),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .byp_raddr (byp_raddr),
        .byp_hit   (byp_hit),
        .byp_data  (byp_data),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b1; in_waddr = 5'd3; in_wdata = 32'h55; rf_grant = 1'b1; byp_raddr = 5'd3;
        step();
        step();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL reset_rf_wen got=%b want=0", rf_wen); end
        total++; if (rf_waddr !== 5'd0) begin bad++; $display("FAIL reset_rf_waddr got=%0d want=0", rf_waddr); end
        total++; if (rf_wdata !== 32'd0) begin bad++; $display("FAIL reset_rf_wdata got=%h want=0", rf_wdata); end
        total++; if (byp_hit !== 1'b0) begin bad++; $display("FAIL reset_byp_hit got=%b want=0", byp_hit); end
        total++; if (byp_data !== 32'd0) begin bad++; $display("FAIL reset_byp_data got=%h want=0", byp_data); end
        total++; if (pending !== 3'd0) begin bad++; $display("FAIL reset_pending got=%0d want=0", pending); end
        in_valid = 1'b0; rst = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready); end
        step();
    endtask

    task automatic test_single();
        rf_grant = 1'b1; in_valid = 1'b1; in_waddr = 5'd5; in_wdata = 32'hDEADBEEF;
        step();
        in_valid = 1'b0; byp_raddr = 5'd5;
        #1;
        total++; if (rf_wen !== 1'b1) begin bad++; $display("FAIL single_wen got=%b want=1", rf_wen); end
        total++; if (rf_waddr !== 5'd5) begin bad++; $display("FAIL single_waddr got=%0d want=5", rf_waddr); end
        total++; if (rf_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_wdata got=%h want=deadbeef", rf_wdata); end
        total++; if (pending !== 3'd1) begin bad++; $display("FAIL single_pending got=%0d want=1", pending); end
        total++; if (byp_hit !== 1'b1 || byp_data !== 32'hDEADBEEF) begin bad++; $display("FAIL single_bypass got=%b/%h want=1/deadbeef", byp_hit, byp_data); end
        step();
        total++; if (pending !== 3'd0) begin bad++; $display("FAIL single_drained got=%0d want=0", pending); end
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL single_wen_after got=%b want=0", rf_wen); end
        total++; if (byp_hit !== 1'b0) begin bad++; $display("FAIL single_byp_after got=%b want=0", byp_hit); end
    endtask

    task automatic test_x0_drop();
        rf_grant = 1'b1; in_valid = 1'b1; in_waddr = 5'd0; in_wdata = 32'h1234;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL x0_in_ready got=%b want=1", in_ready); end
        step();
        in_valid = 1'b0;
        #1;
        total++; if (pending !== 3'd0) begin bad++; $display("FAIL x0_pending got=%0d want=0", pending); end
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL x0_wen got=%b want=0", rf_wen); end
        step();
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL x0_wen_later got=%b want=0", rf_wen); end
    endtask

    task automatic test_backpressure();
        rf_grant = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_waddr = 5'(i); in_wdata = 32'(i * 'h11);
            step();
        end
        total++; if (pending !== 3'd4) begin bad++; $display("FAIL bp_pending got=%0d want=4", pending); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
        total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL bp_wen_held got=%b want=0", rf_wen); end
        in_waddr = 5'd9; in_wdata = 32'h99;
        step();
        total++; if (pending !== 3'd4) begin bad++; $display("FAIL bp_stall_pending got=%0d want=4", pending); end
        in_valid = 1'b0; rf_grant = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'(i) || rf_wdata !== 32'(i * 'h11)) begin bad++; $display("FAIL bp_drain%0d got=%b/%0d/%h want=1/%0d/%h", i, rf_wen, rf_waddr, rf_wdata, i, i * 'h11); end
            step();
        end
        total++; if (pending !== 3'd0 || rf_wen !== 1'b0) begin bad++; $display("FAIL bp_empty got=%0d/%b want=0/0", pending, rf_wen); end
    endtask

    task automatic test_bypass();
        rf_grant = 1'b0; in_valid = 1'b1; in_waddr = 5'd7; in_wdata = 32'hA;
        step();
        in_wdata = 32'hB;
        step();
        in_valid = 1'b0; byp_raddr = 5'd7;
        #1;
        total++; if (byp_hit !== 1'b1 || byp_data !== 32'hB) begin bad++; $display("FAIL byp_youngest got=%b/%h want=1/b", byp_hit, byp_data); end
        byp_raddr = 5'd0;
        #1;
        total++; if (byp_hit !== 1'b0 || byp_data !== 32'd0) begin bad++; $display("FAIL byp_x0 got=%b/%h want=0/0", byp_hit, byp_data); end
        byp_raddr = 5'd8;
        #1;
        total++; if (byp_hit !== 1'b0 || byp_data !== 32'd0) begin bad++; $display("FAIL byp_miss got=%b/%h want=0/0", byp_hit, byp_data); end
        byp_raddr = 5'd7; rf_grant = 1'b1;
        step();
        total++; if (byp_hit !== 1'b1 || byp_data !== 32'hB || pending !== 3'd1) begin bad++; $display("FAIL byp_after_pop got=%b/%h/%0d want=1/b/1", byp_hit, byp_data, pending); end
        step();
        total++; if (byp_hit !== 1'b0 || pending !== 3'd0) begin bad++; $display("FAIL byp_drained got=%b/%0d want=0/0", byp_hit, pending); end
    endtask

    task automatic test_wrap_reset();
        ent_t q[$];
        for (int i = 0; i < 10; i++) begin
            rf_grant = (i >= 2); in_valid = 1'b1; in_waddr = 5'(i + 1); in_wdata = 32'h100 + 32'(i);
            #1;
            total++; if (rf_wen !== (q.size() != 0 && rf_grant)) begin bad++; $display("FAIL wrap_wen%0d got=%b", i, rf_wen); end
            total++; if (pending !== 3'(q.size())) begin bad++; $display("FAIL wrap_pending%0d got=%0d want=%0d", i, pending, q.size()); end
            if (q.size() != 0) begin
                total++; if (rf_waddr !== q[0].a || rf_wdata !== q[0].d) begin bad++; $display("FAIL wrap_head%0d got=%0d/%h want=%0d/%h", i, rf_waddr, rf_wdata, q[0].a, q[0].d); end
                if (rf_grant) void'(q.pop_front());
            end
            q.push_back('{5'(i + 1), 32'h100 + 32'(i)});
            step();
        end
        in_valid = 1'b0; rf_grant = 1'b1;
        for (int n = 0; n < 8 && q.size() != 0; n++) begin
            #1;
            total++; if (rf_wen !== 1'b1 || rf_waddr !== q[0].a || rf_wdata !== q[0].d) begin bad++; $display("FAIL wrap_drain got=%b/%0d/%h want=1/%0d/%h", rf_wen, rf_waddr, rf_wdata, q[0].a, q[0].d); end
            void'(q.pop_front());
            step();
        end
        total++; if (pending !== 3'd0) begin bad++; $display("FAIL wrap_empty got=%0d want=0", pending); end
        rf_grant = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_waddr = 5'(10 + i); in_wdata = 32'hC0 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        total++; if (pending !== 3'd3) begin bad++; $display("FAIL mid_queued got=%0d want=3", pending); end
        rf_grant = 1'b1; rst = 1'b0;
        #1;
        total++; if (pending !== 3'd0 || rf_wen !== 1'b0 || rf_waddr !== 5'd0) begin bad++; $display("FAIL mid_reset got=%0d/%b/%0d want=0/0/0", pending, rf_wen, rf_waddr); end
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (rf_wen !== 1'b0 || pending !== 3'd0) begin bad++; $display("FAIL mid_after%0d got=%b/%0d want=0/0", i, rf_wen, pending); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_x0_drop();
        test_backpressure();
        test_bypass();
        test_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
